mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the mini-CPU datapath bus: services the `Read`/`Write` strobes issued alongside MAR/MDR and returns `Mdatain` to the MDR input mux. It sits between the datapath and a synchronous single-port RAM, inserts a configurable number of wait states, and signals completion with a four-phase `MemReady` handshake. It takes over from bench-driven `Mdatain` so that instruction fetch (T1/T2) and load/store sequences can run against real memory.

## Interface
- `ADDR_W`, 9: word-address width; depth is 2^ADDR_W words.
- `DATA_W`, 32: data width.
- `LATENCY`, 2: wait cycles between request capture and array access; legal range 0–15.

- `Clock` in 1: single clock; all logic on its rising edge.
- `Clear` in 1: synchronous, active-low reset. Sampled at the rising edge of `Clock`.
- `MARaddr` in ADDR_W: word address, taken from the low bits of MAR.
- `MDRdata` in DATA_W: write data from MDR.
- `Read` in 1: read request, level, held by the requester until `MemReady`.
- `Write` in 1: write request, level, held by the requester until `MemReady`.
- `Mdatain` out DATA_W: registered read data to the MDR mux.
- `MemReady` out 1: access complete; held until the request drops.
- `MemBusy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait cycles.
  - ACCESS: performing the array operation.
  - HOLD: waiting for the requester to drop its request.
- Reset (`Clear`=0 at an edge):
  - State goes to IDLE; `Mdatain`=0, `MemReady`=0, `MemBusy`=0; wait counter=0.
  - RAM contents are not cleared.
- IDLE:
  - If `Read` or `Write` is 1, latch `MARaddr`, `MDRdata` and the operation.
  - Load the counter with LATENCY.
  - Next state is WAIT, or ACCESS directly if LATENCY=0.
- WAIT: decrement the counter each cycle; when the counter is 1, go to ACCESS.
- ACCESS, exactly one cycle:
  - Write: store the latched data at the latched address.
  - Read: register the array word at the latched address into `Mdatain`.
  - Set `MemReady`=1 and go to HOLD.
- HOLD:
  - `MemReady` stays 1 while either request is 1.
  - When `Read`=`Write`=0, clear `MemReady` and go to IDLE.
- Simultaneous `Read`=`Write`=1 in IDLE: Write takes priority; one access only; `Mdatain` is unchanged.
- Address, data and request changes after capture are ignored until the return to IDLE.
- `Mdatain` holds the last read value through writes and idle periods. It changes only in ACCESS on a read, or on reset.
- Reset asserted in WAIT or ACCESS aborts the operation. A write aborted before the ACCESS edge does not modify the array.

## Timing
- Request sampled in IDLE at edge k.
- The ACCESS edge is k+1+LATENCY.
- `MemReady` and new `Mdatain` are visible after edge k+1+LATENCY.
- Read latency, request-to-data: LATENCY+2 edges.
- `MemReady` falls one edge after the requester drops both strobes.
- `MemBusy` rises after edge k and falls with `MemReady`.
- Minimum request-to-request spacing is LATENCY+4 edges. This comprises request capture, LATENCY wait cycles, ACCESS, one HOLD edge in which the requester drops its strobes, the return to IDLE, and the IDLE edge that samples the next request.
- A new request held continuously across HOLD is not re-served; strobes must return to 0.

## Structure
- The shared package `cpu_defs` holds:
  - the state encoding (IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10, HOLD=2'b11);
  - `ADDR_W` and `DATA_W` defaults;
  - the width of the wait counter (4 bits).
- Sub-module `mem_array`: single-port synchronous RAM with `we`, `addr`, `wdata` and registered `rdata`, and no reset. `mem_responder` contains the FSM, latches and handshake only.

## Test plan
- Write then read, LATENCY=2:
  - Write 0x4A920000 to address 0x000 and release on `MemReady`.
  - Read address 0x000; `Mdatain`=0x4A920000 with `MemReady` after edge k+3.
  - `MemBusy` high for edges k+1 through HOLD.
- LATENCY=0 instance:
  - Preload address 0x005 = 0x00000022.
  - Read 0x005; `MemReady` and data 0x00000022 appear after edge k+1.
- Simultaneous `Read`=`Write`=1:
  - Set `MDRdata`=0x00000024 at address 0x010.
  - The array location becomes 0x00000024.
  - `Mdatain` keeps its prior value; a single `MemReady` pulse.
- Capture isolation:
  - Change `MARaddr` from 0x001 to 0x002 during WAIT.
  - The read returns the word at 0x001.
- Reset mid-write:
  - Assert `Clear`=0 during WAIT of a write of 0x00000026 to 0x020.
  - Outputs go to 0 at that edge; a subsequent read of 0x020 returns its pre-write contents.
- Held strobe:
  - Hold `Read`=1 for 10 cycles after `MemReady`.
  - Exactly one access occurs; `MemReady` stays 1; it falls one edge after `Read` drops.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the mini-CPU datapath bus: default widths and
// the memory responder state encoding.
package cpu_defs;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWait   = 2'b01,
    StAccess = 2'b10,
    StHold   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: write-enable, registered read data, no reset.
module mem_array #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures Read/Write requests, inserts LATENCY wait
// cycles, performs one array access and completes with a four-phase MemReady.
module mem_responder
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LATENCY = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [ADDR_W-1:0] MARaddr,
  input  logic [DATA_W-1:0] MDRdata,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MemReady,
  output logic              MemBusy
);

  localparam logic [WAIT_CNT_W-1:0] LatCnt = WAIT_CNT_W'(LATENCY);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    is_write_q;
  logic [DATA_W-1:0]       mdatain_q;

  logic                    req;
  logic                    capture;
  logic                    load_rd;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_rdata;

  assign req = Read | Write;

  // State register
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = LatCnt;
          state_d = (LATENCY == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = StAccess;
        end
      end
      StAccess: state_d = StHold;
      StHold: begin
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and control decode. The RAM address follows MARaddr while idle so
  // the registered read port already holds the target word at the ACCESS
  // edge, even with zero wait states.
  always_comb begin
    capture  = 1'b0;
    load_rd  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    MemReady = 1'b0;
    MemBusy  = 1'b1;
    unique case (state_q)
      StIdle: begin
        capture  = req;
        ram_addr = MARaddr;
        MemBusy  = 1'b0;
      end
      StWait: ;
      StAccess: begin
        // A reset landing on the ACCESS edge must not commit the write.
        ram_we  = is_write_q & Clear;
        load_rd = ~is_write_q;
      end
      StHold: MemReady = 1'b1;
      default: MemBusy = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      mdatain_q  <= '0;
    end else begin
      if (capture) begin
        addr_q     <= MARaddr;
        wdata_q    <= MDRdata;
        is_write_q <= Write;
      end
      if (load_rd) begin
        mdatain_q <= ram_rdata;
      end
    end
  end

  assign Mdatain = mdatain_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .Clock (Clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized accesses against a word-array
// model, plus a zero-latency instance exercised directly.
module tb_mem_responder;

  localparam int unsigned AW  = 9;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          Clock = 1'b0;
  logic          Clear;
  logic [AW-1:0] MARaddr;
  logic [DW-1:0] MDRdata;
  logic          Read, Write;
  logic [DW-1:0] Mdatain;
  logic          MemReady, MemBusy;

  logic [AW-1:0] mar0;
  logic [DW-1:0] mdr0;
  logic          rd0, wr0;
  logic [DW-1:0] mdat0;
  logic          rdy0, busy0;

  always #5 Clock = ~Clock;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .MARaddr  (MARaddr),
    .MDRdata  (MDRdata),
    .Read     (Read),
    .Write    (Write),
    .Mdatain  (Mdatain),
    .MemReady (MemReady),
    .MemBusy  (MemBusy)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(0)) dut0 (
    .Clock    (Clock),
    .Clear    (Clear),
    .MARaddr  (mar0),
    .MDRdata  (mdr0),
    .Read     (rd0),
    .Write    (wr0),
    .Mdatain  (mdat0),
    .MemReady (rdy0),
    .MemBusy  (busy0)
  );

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] mem_m [64];
  logic [DW-1:0] last_rd;
  logic [DW-1:0] exp_q [$];
  bit            mon_en = 1'b0;
  logic          rdy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every rising MemReady must match exactly one issued transaction.
  always @(negedge Clock) begin
    if (mon_en && MemReady && !rdy_prev) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else chk("mdatain", Mdatain, exp_q.pop_front());
    end
    rdy_prev <= MemReady;
  end

  // Issue one request at a negedge; returns at a negedge with the bus idle.
  task automatic xact(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int hold, input bit scramble);
    int n;
    bit got;
    MARaddr = a;
    MDRdata = d;
    Read    = rd;
    Write   = wr;
    if (wr) mem_m[a[5:0]] = d;
    else    last_rd = mem_m[a[5:0]];
    exp_q.push_back(last_rd);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge Clock);
      @(negedge Clock);
      n++;
      chk("busy_during_access", 32'(MemBusy), 32'd1);
      if (MemReady) got = 1'b1;
      else if (scramble) begin
        MARaddr = a + 1'b1;
        MDRdata = ~d;
      end
    end
    chk("ready_latency", 32'(n), 32'(LAT + 2));
    for (int i = 0; i < hold; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      chk("ready_held", 32'(MemReady), 32'd1);
    end
    Read  = 1'b0;
    Write = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("ready_fall", 32'(MemReady), 32'd0);
    chk("busy_fall", 32'(MemBusy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int op;
    Clear   = 1'b0;
    MARaddr = '0;
    MDRdata = '0;
    Read    = 1'b0;
    Write   = 1'b0;
    mar0    = '0;
    mdr0    = '0;
    rd0     = 1'b0;
    wr0     = 1'b0;
    last_rd = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("reset_mdatain", Mdatain, 32'd0);
    chk("reset_ready", 32'(MemReady), 32'd0);
    chk("reset_busy", 32'(MemBusy), 32'd0);
    chk("reset0_ready", 32'(rdy0), 32'd0);
    Clear  = 1'b1;
    mon_en = 1'b1;

    // Zero-latency instance: preload 0x005 then read it back.
    mar0 = 9'h005;
    mdr0 = 32'h0000_0022;
    wr0  = 1'b1;
    n    = 0;
    do begin
      @(posedge Clock);
      @(negedge Clock);
      n++;
    end while (!rdy0 && n < 20);
    chk("lat0_write_latency", 32'(n), 32'd2);
    wr0 = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    rd0 = 1'b1;
    n   = 0;
    do begin
      @(posedge Clock);
      @(negedge Clock);
      n++;
    end while (!rdy0 && n < 20);
    chk("lat0_read_latency", 32'(n), 32'd2);
    chk("lat0_read_data", mdat0, 32'h0000_0022);
    rd0 = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("lat0_ready_fall", 32'(rdy0), 32'd0);

    // Give every modelled location known contents.
    for (int a = 0; a < 64; a++) xact(1'b0, 1'b1, AW'(a), $urandom, 0, 1'b0);

    xact(1'b0, 1'b1, 9'h000, 32'h4A92_0000, 0, 1'b0);
    xact(1'b1, 1'b0, 9'h000, 32'h0, 0, 1'b0);
    xact(1'b1, 1'b1, 9'h010, 32'h0000_0024, 0, 1'b0);
    xact(1'b1, 1'b0, 9'h010, 32'h0, 0, 1'b0);
    xact(1'b1, 1'b0, 9'h001, 32'h0, 0, 1'b1);

    // Reset during WAIT of a write: no array update, outputs cleared.
    MARaddr = 9'h020;
    MDRdata = 32'h0000_0026;
    Write   = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("abort_busy", 32'(MemBusy), 32'd1);
    Clear = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("abort_mdatain", Mdatain, 32'd0);
    chk("abort_ready", 32'(MemReady), 32'd0);
    chk("abort_busy_clr", 32'(MemBusy), 32'd0);
    last_rd = '0;
    Write   = 1'b0;
    Clear   = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    xact(1'b1, 1'b0, 9'h020, 32'h0, 0, 1'b0);

    xact(1'b1, 1'b0, AW'($urandom_range(0, 63)), 32'h0, 10, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      xact(op != 1, op != 0, AW'($urandom_range(0, 63)), $urandom,
           $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
